intc_prio: RTL and testbench

//  Priority interrupt controller between external request lines and the CPU's intr/inta handshake.

---
 rtl/intc_prio.sv | 199 +++++++++++++++++++
 tb/tb_intc_prio.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_prio.sv
// -----------------------------------------------------------------------------
// intc_prio -- priority interrupt controller
//
// Sits between NSRC external request lines and the CPU's intr/inta handshake.
// Rising edges on irq are latched into pend. Sources that are both pending and
// unmasked raise intr. On inta the lowest-numbered eligible source (index 0 is
// the highest priority) is selected, its vector is published on vec, and no
// further interrupt is raised until software writes EOI.
//
// Ports
//   clk        in   1     system clock, all state updates on the rising edge
//   clr        in   1     synchronous active-high reset
//   irq        in   NSRC  raw request lines, synchronous to clk, edge-triggered
//   intr       out  1     interrupt request to the CPU (decoded from state flop)
//   inta       in   1     CPU acknowledge, one-cycle pulse
//   vec        out  VW    vector of the source in service
//   spur       out  1     last acknowledge found nothing eligible
//   cfg_we     in   1     config write strobe
//   cfg_addr   in   2     0=MASK 1=PEND 2=STAT 3=EOI
//   cfg_wdata  in   32    config write data
//   cfg_rdata  out  32    config read data, combinational from cfg_addr
//
// Register map
//   MASK (0) rw   bits [NSRC-1:0], upper bits read 0
//   PEND (1) r/w1c; a new edge in the same cycle keeps the bit set
//   STAT (2) ro   bit9=spur, bit8=in service, bits[VW-1:0]=vec
//   EOI  (3) wo   any write ends the current service; reads 0
// -----------------------------------------------------------------------------
module intc_prio #(
    parameter int NSRC = 8,
    parameter int VW   = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [NSRC-1:0] irq,
    output logic            intr,
    input  logic            inta,
    output logic [VW-1:0]   vec,
    output logic            spur,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [31:0]     cfg_wdata,
    output logic [31:0]     cfg_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_PEND = 2'd1;
    localparam logic [1:0] A_STAT = 2'd2;
    localparam logic [1:0] A_EOI  = 2'd3;

    state_t          state;
    state_t          state_n;

    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] pend_n;
    logic [NSRC-1:0] irq_q;
    logic [NSRC-1:0] edges;
    logic [NSRC-1:0] elig;
    logic            any;
    logic [VW-1:0]   sel;

    logic            wr_mask;
    logic            wr_pend;
    logic            wr_eoi;
    logic            do_sel;
    logic            do_spur;

    // Only the low NSRC bits of write data reach a register.
    generate
        if (NSRC < 32) begin : g_unused
            logic unused_wdata;
            assign unused_wdata = ^cfg_wdata[31:NSRC];
        end
    endgenerate

    assign wr_mask = cfg_we && (cfg_addr == A_MASK);
    assign wr_pend = cfg_we && (cfg_addr == A_PEND);
    assign wr_eoi  = cfg_we && (cfg_addr == A_EOI);

    assign edges = irq & ~irq_q;
    assign elig  = pend & mask;
    assign any   = |elig;

    // intr decodes straight from the state flop, so it is glitch-free and
    // rises one edge after 'any' first becomes true in IDLE.
    assign intr  = (state == S_ASSERT);

    // Lowest set index wins: scan from the top so the last hit is the winner.
    always_comb begin
        sel = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (elig[i]) sel = VW'(i);
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and the one-cycle actions it requests
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_n = state;
        do_sel  = 1'b0;
        do_spur = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (any) state_n = S_ASSERT;
            end
            S_ASSERT: begin
                if (inta) begin
                    if (any) begin
                        do_sel  = 1'b1;
                        state_n = S_SERVICE;
                    end else begin
                        // Request withdrawn in the very cycle it was acked.
                        do_spur = 1'b1;
                        state_n = S_IDLE;
                    end
                end else if (!any) begin
                    state_n = S_IDLE;
                end
            end
            S_SERVICE: begin
                // No nesting: edges here only latch pend until EOI.
                if (wr_eoi) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pending update. Ordering matters: clears are applied first and new
    // edges are OR-ed in last, so a same-cycle edge always keeps its bit set.
    // The selection above used the pre-clear pend, so a W1C racing inta
    // cannot change which source is serviced.
    always_comb begin
        pend_n = pend;
        if (do_sel)  pend_n[sel] = 1'b0;
        if (wr_pend) pend_n = pend_n & ~cfg_wdata[NSRC-1:0];
        pend_n = pend_n | edges;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (clr) state <= S_IDLE;
        else     state <= state_n;
    end

    // irq_q clears on reset, so a line held high through reset release is
    // seen as exactly one rising edge on the first active cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            mask  <= '0;
            pend  <= '0;
            irq_q <= '0;
            vec   <= '0;
            spur  <= 1'b0;
        end else begin
            irq_q <= irq;
            pend  <= pend_n;
            if (wr_mask) mask <= cfg_wdata[NSRC-1:0];
            if (do_sel) begin
                vec  <= sel;
                spur <= 1'b0;
            end else if (do_spur) begin
                vec  <= '1;
                spur <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Config read mux
    // -------------------------------------------------------------------------
    always_comb begin
        cfg_rdata = '0;
        unique case (cfg_addr)
            A_MASK: cfg_rdata[NSRC-1:0] = mask;
            A_PEND: cfg_rdata[NSRC-1:0] = pend;
            A_STAT: begin
                cfg_rdata[9]      = spur;
                cfg_rdata[8]      = (state == S_SERVICE);
                cfg_rdata[VW-1:0] = vec;
            end
            default: cfg_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intc_prio.sv
// -----------------------------------------------------------------------------
// tb_intc_prio -- directed scoreboard bench for intc_prio (NSRC=8, VW=3)
//
// Expected values are pushed into a queue as each stimulus step is driven and
// popped and compared against the DUT once the step's clock edge has passed.
// Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_intc_prio;

    localparam int NSRC = 8;
    localparam int VW   = 3;

    logic            clk;
    logic            clr;
    logic [NSRC-1:0] irq;
    logic            intr;
    logic            inta;
    logic [VW-1:0]   vec;
    logic            spur;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;

    intc_prio #(.NSRC(NSRC), .VW(VW)) dut (
        .clk       (clk),
        .clr       (clr),
        .irq       (irq),
        .intr      (intr),
        .inta      (inta),
        .vec       (vec),
        .spur      (spur),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef enum int {K_INTR, K_VEC, K_SPUR, K_RD} kind_t;

    typedef struct {
        kind_t       kind;
        logic [1:0]  addr;
        logic [31:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    localparam logic [1:0] MASK = 2'd0;
    localparam logic [1:0] PEND = 2'd1;
    localparam logic [1:0] STAT = 2'd2;
    localparam logic [1:0] EOI  = 2'd3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic push(input kind_t k, input logic [1:0] a,
                        input logic [31:0] v, input string t);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.val  = v;
        e.tag  = t;
        sb.push_back(e);
    endtask

    // Pop every queued expectation and compare it with the DUT's output now.
    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_INTR: obs = {31'b0, intr};
                K_VEC:  obs = {29'b0, vec};
                K_SPUR: obs = {31'b0, spur};
                default: begin
                    cfg_addr = e.addr;
                    #1;
                    obs = cfg_rdata;
                end
            endcase
            n_total++;
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
        end
    endtask

    task automatic pulse_irq(input logic [NSRC-1:0] m);
        irq = m;
        tick();
        irq = '0;
    endtask

    task automatic ack();
        inta = 1'b1;
        tick();
        inta = 1'b0;
    endtask

    initial begin
        clr       = 1'b1;
        irq       = '0;
        inta      = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        push(K_INTR, 0, 0, "rst_intr");
        push(K_VEC,  0, 0, "rst_vec");
        push(K_SPUR, 0, 0, "rst_spur");
        push(K_RD, MASK, 0, "rst_mask");
        push(K_RD, PEND, 0, "rst_pend");
        push(K_RD, STAT, 0, "rst_stat");
        drain();
        clr = 1'b0;

        // ---------------- 1: single source ----------------
        cfg_write(MASK, 32'hFF);
        push(K_RD, MASK, 32'hFF, "t1_mask");
        drain();
        pulse_irq(8'h20);
        push(K_RD, PEND, 32'h20, "t1_pend_latched");
        push(K_INTR, 0, 0, "t1_intr_not_yet");
        drain();
        tick();
        push(K_INTR, 0, 1, "t1_intr_2clk");
        drain();
        ack();
        push(K_VEC, 0, 5, "t1_vec");
        push(K_INTR, 0, 0, "t1_intr_drop");
        push(K_RD, PEND, 32'h00, "t1_pend_cleared");
        push(K_RD, STAT, 32'h105, "t1_stat_service");
        drain();
        ack();  // inta outside ASSERT is ignored
        push(K_RD, STAT, 32'h105, "t1_stray_inta");
        drain();
        cfg_write(EOI, 32'h0);
        push(K_RD, STAT, 32'h005, "t1_eoi_idle");
        drain();
        tick();
        push(K_INTR, 0, 0, "t1_idle_quiet");
        drain();

        // ---------------- 2: priority between two sources ----------------
        pulse_irq(8'h44);
        tick();
        push(K_INTR, 0, 1, "t2_intr");
        drain();
        ack();
        push(K_VEC, 0, 2, "t2_vec_first");
        push(K_RD, PEND, 32'h40, "t2_pend_left");
        push(K_INTR, 0, 0, "t2_intr_service");
        drain();
        cfg_write(EOI, 32'h0);
        push(K_INTR, 0, 0, "t2_intr_after_eoi");
        drain();
        tick();
        push(K_INTR, 0, 1, "t2_intr_rerise");
        drain();
        ack();
        push(K_VEC, 0, 6, "t2_vec_second");
        push(K_RD, PEND, 32'h00, "t2_pend_empty");
        drain();
        cfg_write(EOI, 32'h0);
        tick();

        // ---------------- 3: masked source ----------------
        cfg_write(MASK, 32'h00);
        pulse_irq(8'h02);
        tick();
        tick();
        push(K_RD, PEND, 32'h02, "t3_pend_masked");
        push(K_INTR, 0, 0, "t3_intr_masked");
        drain();
        cfg_write(MASK, 32'h02);
        push(K_INTR, 0, 0, "t3_intr_at_unmask");
        drain();
        tick();
        push(K_INTR, 0, 1, "t3_intr_unmasked");
        drain();

        // ---------------- 4a: W1C races inta ----------------
        cfg_we    = 1'b1;
        cfg_addr  = PEND;
        cfg_wdata = 32'hFFFF_FFFF;
        inta      = 1'b1;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        inta      = 1'b0;
        push(K_VEC, 0, 1, "t4_vec_preclear");
        push(K_RD, STAT, 32'h101, "t4_stat_service");
        push(K_RD, PEND, 32'h00, "t4_pend_cleared");
        drain();
        cfg_write(EOI, 32'h0);

        // ---------------- 4b: W1C alone withdraws intr ----------------
        cfg_write(MASK, 32'hFF);
        pulse_irq(8'h10);
        tick();
        push(K_INTR, 0, 1, "t4b_intr");
        drain();
        cfg_write(PEND, 32'hFFFF_FFFF);
        push(K_RD, PEND, 32'h00, "t4b_pend_w1c");
        drain();
        tick();
        push(K_INTR, 0, 0, "t4b_intr_withdrawn");
        push(K_RD, STAT, 32'h001, "t4b_stat_idle");
        push(K_SPUR, 0, 0, "t4b_no_spur");
        drain();

        // ---------------- spurious acknowledge ----------------
        pulse_irq(8'h08);
        tick();
        push(K_INTR, 0, 1, "sp_intr");
        drain();
        cfg_write(PEND, 32'h08);  // any drops while state is still ASSERT
        ack();
        push(K_SPUR, 0, 1, "sp_spur");
        push(K_VEC, 0, 7, "sp_vec_ones");
        push(K_INTR, 0, 0, "sp_intr");
        push(K_RD, STAT, 32'h207, "sp_stat");
        drain();

        // ---------------- same-cycle edge beats W1C / select clear ----------
        cfg_we    = 1'b1;
        cfg_addr  = PEND;
        cfg_wdata = 32'h80;
        irq       = 8'h80;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
        irq       = '0;
        push(K_RD, PEND, 32'h80, "sim_w1c_vs_edge");
        drain();
        tick();
        push(K_INTR, 0, 1, "sim_intr");
        drain();
        inta = 1'b1;
        irq  = 8'h80;
        tick();
        inta = 1'b0;
        irq  = '0;
        push(K_VEC, 0, 7, "sim_vec");
        push(K_SPUR, 0, 0, "sim_spur_cleared");
        push(K_RD, PEND, 32'h80, "sim_sel_vs_edge");
        push(K_RD, STAT, 32'h107, "sim_stat");
        drain();

        // ---------------- 5: edge during service ----------------
        pulse_irq(8'h01);
        push(K_INTR, 0, 0, "t5_no_nesting");
        push(K_RD, PEND, 32'h81, "t5_pend");
        drain();
        tick();
        push(K_INTR, 0, 0, "t5_still_service");
        drain();
        cfg_write(EOI, 32'h0);
        push(K_INTR, 0, 0, "t5_eoi_edge");
        drain();
        tick();
        push(K_INTR, 0, 1, "t5_intr_after_eoi");
        drain();
        ack();
        push(K_VEC, 0, 0, "t5_vec0");
        push(K_RD, PEND, 32'h80, "t5_pend_after");
        drain();
        cfg_write(EOI, 32'h0);
        tick();
        ack();
        push(K_VEC, 0, 7, "t5_vec7");
        push(K_RD, STAT, 32'h107, "t5_stat_service");
        drain();

        // ---------------- 6: reset mid-service, line held high ----------------
        irq = 8'h08;
        clr = 1'b1;
        tick();
        push(K_INTR, 0, 0, "t6_intr");
        push(K_VEC, 0, 0, "t6_vec");
        push(K_SPUR, 0, 0, "t6_spur");
        push(K_RD, STAT, 32'h0, "t6_stat");
        push(K_RD, PEND, 32'h0, "t6_pend");
        push(K_RD, MASK, 32'h0, "t6_mask");
        drain();
        tick();
        clr = 1'b0;
        tick();
        push(K_RD, PEND, 32'h08, "t6_one_edge");
        drain();
        cfg_write(PEND, 32'h08);
        push(K_RD, PEND, 32'h00, "t6_w1c");
        drain();
        tick();
        tick();
        push(K_RD, PEND, 32'h00, "t6_no_relatch");
        push(K_INTR, 0, 0, "t6_intr_masked");
        drain();
        irq = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
